// File: rtl/vx_sched_csr_ctrl_pkg.sv
// Shared definitions for the scheduler-side CSR control block.
// Holds default sizing values used when the block is instantiated without
// overrides, and the reset identity of the warp that is alive out of reset.
package vx_sched_csr_ctrl_pkg;

  localparam int THREAD_CNT_DEF    = 4;
  localparam int WARP_CNT_DEF      = 4;
  localparam int PEND_W_DEF        = 4;
  localparam int ALM_THRESH_DEF    = 1;
  localparam int PERF_CTR_BITS_DEF = 44;

  // Warp that is active (with a full thread mask) after reset.
  localparam int RESET_WID = 0;

  // Per-warp in-flight count at the default width.
  typedef logic [PEND_W_DEF-1:0] pend_cnt_t;

endpackage

// File: rtl/vx_sched_csr_ctrl_pend_ctr.sv
// Per-warp in-flight instruction counter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inc        : one instruction issued to this warp this cycle
//   dec        : one instruction retired from this warp this cycle
//   count      : registered in-flight count
//   full       : count is at its maximum (2^PEND_W-1)
// inc and dec together leave the count unchanged. Increment saturates at
// the maximum; a decrement at zero holds zero and trips a sim-only check.
module vx_sched_csr_ctrl_pend_ctr #(
  parameter int PEND_W        = 4,
  parameter bit UNDERFLOW_CHK = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              full
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  assign full = (count == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + PEND_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - PEND_W'(1);
    end
  end

  // A retire with nothing in flight means the issue/commit bookkeeping
  // upstream has gone wrong; the counter itself just holds zero.
  if (UNDERFLOW_CHK) begin : g_underflow_chk
    always_ff @(posedge clk) begin
      if (!reset) begin
        assert (!(dec && !inc && (count == '0)))
          else $error("pend_ctr: commit with zero instructions in flight");
      end
    end
  end

endmodule

// File: rtl/vx_sched_csr_ctrl.sv
// Scheduler-side master of the scheduler/CSR interface.
// Owns the free-running cycle counter, per-warp active bits and thread
// masks, per-warp in-flight counters (for the CSR almost-empty query) and
// per-warp CSR issue locks released by the CSR unit.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   issue_valid/wid/is_csr        : instruction issued (CSR ops lock the warp)
//   commit_valid/wid              : instruction retired
//   tmc_valid/wid/tmask           : thread-mask write for one warp
//   spawn_valid/wmask             : activate a set of warps with full masks
//   cycles                        : cycle counter
//   active_warps, thread_masks    : registered warp state
//   alm_empty, alm_empty_wid      : almost-empty answer for the queried warp
//   unlock_warp/wid               : CSR lock release from the CSR unit
//   warp_locked, pend_full        : per-warp issue blockers
// Interface timing: every *_valid / unlock_warp input is a single-cycle
// event strobe sampled on each rising clk edge. There is no backpressure;
// the scheduler must consult warp_locked and pend_full before raising
// issue_valid for a warp. Any warp id >= WARP_CNT is ignored.
module vx_sched_csr_ctrl
  import vx_sched_csr_ctrl_pkg::*;
#(
  parameter int THREAD_CNT     = THREAD_CNT_DEF,
  parameter int WARP_CNT       = WARP_CNT_DEF,
  parameter int WARP_CNT_WIDTH = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1,
  parameter int PEND_W         = PEND_W_DEF,
  parameter int ALM_THRESH     = ALM_THRESH_DEF,
  parameter int PERF_CTR_BITS  = PERF_CTR_BITS_DEF,
  parameter bit UNDERFLOW_CHK  = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue_valid,
  input  logic [WARP_CNT_WIDTH-1:0]      issue_wid,
  input  logic                           issue_is_csr,
  input  logic                           commit_valid,
  input  logic [WARP_CNT_WIDTH-1:0]      commit_wid,
  input  logic                           tmc_valid,
  input  logic [WARP_CNT_WIDTH-1:0]      tmc_wid,
  input  logic [THREAD_CNT-1:0]          tmc_tmask,
  input  logic                           spawn_valid,
  input  logic [WARP_CNT-1:0]            spawn_wmask,
  output logic [PERF_CTR_BITS-1:0]       cycles,
  output logic [WARP_CNT-1:0]            active_warps,
  output logic [WARP_CNT*THREAD_CNT-1:0] thread_masks,
  output logic                           alm_empty,
  input  logic [WARP_CNT_WIDTH-1:0]      alm_empty_wid,
  input  logic                           unlock_warp,
  input  logic [WARP_CNT_WIDTH-1:0]      unlock_wid,
  output logic [WARP_CNT-1:0]            warp_locked,
  output logic [WARP_CNT-1:0]            pend_full
);

  localparam logic [WARP_CNT-1:0] RESET_ACTIVE =
    WARP_CNT'(1) << RESET_WID;
  localparam logic [WARP_CNT*THREAD_CNT-1:0] RESET_TMASKS =
    (WARP_CNT*THREAD_CNT)'({THREAD_CNT{1'b1}}) << (RESET_WID*THREAD_CNT);

  // One-hot decode of each warp-id input. Comparing against every legal
  // index means an out-of-range id simply matches nothing.
  logic [WARP_CNT-1:0] issue_hit;
  logic [WARP_CNT-1:0] csr_hit;
  logic [WARP_CNT-1:0] commit_hit;
  logic [WARP_CNT-1:0] tmc_hit;
  logic [WARP_CNT-1:0] unlock_hit;

  always_comb begin
    issue_hit  = '0;
    csr_hit    = '0;
    commit_hit = '0;
    tmc_hit    = '0;
    unlock_hit = '0;
    for (int w = 0; w < WARP_CNT; w++) begin
      issue_hit[w]  = issue_valid  && (issue_wid  == WARP_CNT_WIDTH'(w));
      csr_hit[w]    = issue_hit[w] && issue_is_csr;
      commit_hit[w] = commit_valid && (commit_wid == WARP_CNT_WIDTH'(w));
      tmc_hit[w]    = tmc_valid    && (tmc_wid    == WARP_CNT_WIDTH'(w));
      unlock_hit[w] = unlock_warp  && (unlock_wid == WARP_CNT_WIDTH'(w));
    end
  end

  // Free-running cycle counter, wraps naturally at its width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + PERF_CTR_BITS'(1);
    end
  end

  // Active bits and thread masks. The TMC assignment comes after the spawn
  // assignment so that TMC wins when both target the same warp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_warps <= RESET_ACTIVE;
      thread_masks <= RESET_TMASKS;
    end else begin
      for (int w = 0; w < WARP_CNT; w++) begin
        if (spawn_valid && spawn_wmask[w]) begin
          active_warps[w]                           <= 1'b1;
          thread_masks[w*THREAD_CNT +: THREAD_CNT] <= '1;
        end
        if (tmc_hit[w]) begin
          active_warps[w]                           <= |tmc_tmask;
          thread_masks[w*THREAD_CNT +: THREAD_CNT] <= tmc_tmask;
        end
      end
    end
  end

  // CSR issue locks. A new CSR issue beats a release arriving in the same
  // cycle, since the release belongs to the previous CSR op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warp_locked <= '0;
    end else begin
      for (int w = 0; w < WARP_CNT; w++) begin
        if (csr_hit[w]) begin
          warp_locked[w] <= 1'b1;
        end else if (unlock_hit[w]) begin
          warp_locked[w] <= 1'b0;
        end
      end
    end
  end

  logic [PEND_W-1:0] pend_cnt [WARP_CNT];

  for (genvar w = 0; w < WARP_CNT; w++) begin : g_pend
    vx_sched_csr_ctrl_pend_ctr #(
      .PEND_W        (PEND_W),
      .UNDERFLOW_CHK (UNDERFLOW_CHK)
    ) u_pend_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (issue_hit[w]),
      .dec   (commit_hit[w]),
      .count (pend_cnt[w]),
      .full  (pend_full[w])
    );
  end

  // The querying CSR op is itself in flight, hence the threshold rather
  // than a compare against zero. A nonexistent warp has nothing in flight.
  always_comb begin
    alm_empty = 1'b1;
    for (int w = 0; w < WARP_CNT; w++) begin
      if (alm_empty_wid == WARP_CNT_WIDTH'(w)) begin
        alm_empty = (pend_cnt[w] <= PEND_W'(ALM_THRESH));
      end
    end
  end

endmodule

// File: tb/tb_vx_sched_csr_ctrl.sv
// Testbench for vx_sched_csr_ctrl: directed scenarios plus randomized
// traffic, checked cycle by cycle against a behavioural model.
module tb_vx_sched_csr_ctrl;

  localparam int TC   = 4;
  localparam int WC   = 4;
  localparam int WW   = 3;
  localparam int PW   = 4;
  localparam int PCB  = 8;
  localparam int PMAX = 15;
  localparam int EW   = PCB + WC + WC*TC + WC + WC + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              issue_valid;
  logic [WW-1:0]     issue_wid;
  logic              issue_is_csr;
  logic              commit_valid;
  logic [WW-1:0]     commit_wid;
  logic              tmc_valid;
  logic [WW-1:0]     tmc_wid;
  logic [TC-1:0]     tmc_tmask;
  logic              spawn_valid;
  logic [WC-1:0]     spawn_wmask;
  logic [PCB-1:0]    cycles;
  logic [WC-1:0]     active_warps;
  logic [WC*TC-1:0]  thread_masks;
  logic              alm_empty;
  logic [WW-1:0]     alm_empty_wid;
  logic              unlock_warp;
  logic [WW-1:0]     unlock_wid;
  logic [WC-1:0]     warp_locked;
  logic [WC-1:0]     pend_full;

  vx_sched_csr_ctrl #(
    .THREAD_CNT     (TC),
    .WARP_CNT       (WC),
    .WARP_CNT_WIDTH (WW),
    .PEND_W         (PW),
    .ALM_THRESH     (1),
    .PERF_CTR_BITS  (PCB),
    .UNDERFLOW_CHK  (1'b0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_wid     (issue_wid),
    .issue_is_csr  (issue_is_csr),
    .commit_valid  (commit_valid),
    .commit_wid    (commit_wid),
    .tmc_valid     (tmc_valid),
    .tmc_wid       (tmc_wid),
    .tmc_tmask     (tmc_tmask),
    .spawn_valid   (spawn_valid),
    .spawn_wmask   (spawn_wmask),
    .cycles        (cycles),
    .active_warps  (active_warps),
    .thread_masks  (thread_masks),
    .alm_empty     (alm_empty),
    .alm_empty_wid (alm_empty_wid),
    .unlock_warp   (unlock_warp),
    .unlock_wid    (unlock_wid),
    .warp_locked   (warp_locked),
    .pend_full     (pend_full)
  );

  // ---------------- reference model ----------------
  int           m_cyc;
  int           m_pend [WC];
  bit           m_act  [WC];
  logic [TC-1:0] m_tm  [WC];
  bit           m_lock [WC];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    for (int w = 0; w < WC; w++) begin
      m_pend[w] = 0;
      m_act[w]  = (w == 0);
      m_tm[w]   = (w == 0) ? '1 : '0;
      m_lock[w] = 1'b0;
    end
  endtask

  function automatic logic [EW-1:0] model_expect();
    logic [WC-1:0]    a, l, f;
    logic [WC*TC-1:0] m;
    logic             al;
    for (int w = 0; w < WC; w++) begin
      a[w]          = m_act[w];
      l[w]          = m_lock[w];
      f[w]          = (m_pend[w] == PMAX);
      m[w*TC +: TC] = m_tm[w];
    end
    al = (alm_empty_wid < WC) ? (m_pend[alm_empty_wid] <= 1) : 1'b1;
    return {PCB'(m_cyc), a, m, l, f, al};
  endfunction

  // One clock of the rules, applied to whatever is on the DUT inputs now.
  task automatic model_step();
    m_cyc = (m_cyc + 1) % (1 << PCB);
    for (int w = 0; w < WC; w++) begin
      int d;
      d = ((issue_valid && issue_wid == w) ? 1 : 0) - ((commit_valid && commit_wid == w) ? 1 : 0);
      if (d > 0 && m_pend[w] < PMAX) m_pend[w]++;
      if (d < 0 && m_pend[w] > 0) m_pend[w]--;
      if (spawn_valid && spawn_wmask[w]) begin
        m_act[w] = 1'b1;
        m_tm[w]  = '1;
      end
      if (tmc_valid && tmc_wid == w) begin
        m_act[w] = (tmc_tmask != 0);
        m_tm[w]  = tmc_tmask;
      end
      if (issue_valid && issue_is_csr && issue_wid == w) m_lock[w] = 1'b1;
      else if (unlock_warp && unlock_wid == w) m_lock[w] = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    issue_valid  = 1'b0; issue_wid  = '0; issue_is_csr = 1'b0;
    commit_valid = 1'b0; commit_wid = '0;
    tmc_valid    = 1'b0; tmc_wid    = '0; tmc_tmask    = '0;
    spawn_valid  = 1'b0; spawn_wmask = '0;
    unlock_warp  = 1'b0; unlock_wid = '0;
  endtask

  // Called at a negedge with inputs already set: predict, then hold them
  // across the next rising edge.
  task automatic step();
    model_step();
    exp_q.push_back(model_expect());
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    alm_empty_wid = '0;
    model_reset();
    exp_q.delete();
    #1;
    chk("rst_cycles", cycles, 0);
    chk("rst_active", active_warps, 4'b0001);
    chk("rst_tmasks", thread_masks, 16'h000F);
    chk("rst_locked", warp_locked, 0);
    chk("rst_full", pend_full, 0);
    chk("rst_alm", alm_empty, 1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [EW-1:0] mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("cycles",       cycles,       mon_e[EW-1 -: PCB]);
      chk("active_warps", active_warps, mon_e[EW-PCB-1 -: WC]);
      chk("thread_masks", thread_masks, mon_e[EW-PCB-WC-1 -: WC*TC]);
      chk("warp_locked",  warp_locked,  mon_e[2*WC -: WC]);
      chk("pend_full",    pend_full,    mon_e[WC:1]);
      chk("alm_empty",    alm_empty,    mon_e[0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    clear_inputs();
    alm_empty_wid = '0;
    #2;
    do_reset();

    // Counter after 10 clocks, then an asynchronous reset mid-count.
    for (int i = 0; i < 10; i++) step();
    chk("cycles_10", cycles, 10);
    spawn_valid = 1'b1; spawn_wmask = 4'b1110; step();
    issue_valid = 1'b1; issue_wid = 3'd1; issue_is_csr = 1'b1; step();
    do_reset();

    // Almost-empty tracking on warp 2.
    alm_empty_wid = 3'd2;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_wid = 3'd2; step();
    end
    commit_valid = 1'b1; commit_wid = 3'd2; step();
    chk("alm_pend2", alm_empty, 0);
    commit_valid = 1'b1; commit_wid = 3'd2; step();
    chk("alm_pend1", alm_empty, 1);

    // Simultaneous issue/commit, then a commit with nothing in flight.
    alm_empty_wid = 3'd1;
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1; issue_wid = 3'd1;
      commit_valid = 1'b1; commit_wid = 3'd1; step();
    end
    commit_valid = 1'b1; commit_wid = 3'd1; step();
    chk("underflow_full", pend_full, 0);

    // CSR lock set, release, and set+release together.
    issue_valid = 1'b1; issue_wid = 3'd3; issue_is_csr = 1'b1; step();
    chk("lock_set", warp_locked, 4'b1000);
    unlock_warp = 1'b1; unlock_wid = 3'd3; step();
    chk("lock_clr", warp_locked, 4'b0000);
    unlock_warp = 1'b1; unlock_wid = 3'd3; step();
    chk("unlock_noop", warp_locked, 4'b0000);
    issue_valid = 1'b1; issue_wid = 3'd3; issue_is_csr = 1'b1;
    unlock_warp = 1'b1; unlock_wid = 3'd3; step();
    chk("lock_set_wins", warp_locked, 4'b1000);

    // Spawn and TMC on the same warp in the same cycle.
    do_reset();
    spawn_valid = 1'b1; spawn_wmask = 4'b0110;
    tmc_valid = 1'b1; tmc_wid = 3'd1; tmc_tmask = 4'b0000; step();
    chk("spawn_tmc_active", active_warps, 4'b0101);
    chk("spawn_tmc_masks", thread_masks, 16'h0F0F);

    // Saturation of the in-flight counter on warp 0.
    alm_empty_wid = 3'd0;
    for (int i = 0; i < 15; i++) begin
      issue_valid = 1'b1; issue_wid = 3'd0; step();
    end
    chk("full_at_15", pend_full, 4'b0001);
    issue_valid = 1'b1; issue_wid = 3'd0; step();
    chk("full_after_16", pend_full, 4'b0001);
    for (int i = 0; i < 14; i++) begin
      commit_valid = 1'b1; commit_wid = 3'd0; step();
    end
    chk("drain_to_1", alm_empty, 1);

    // Out-of-range warp ids must not disturb anything.
    issue_valid = 1'b1; issue_wid = 3'd5; issue_is_csr = 1'b1;
    commit_valid = 1'b1; commit_wid = 3'd4;
    tmc_valid = 1'b1; tmc_wid = 3'd6; tmc_tmask = 4'b0000;
    unlock_warp = 1'b1; unlock_wid = 3'd7; step();

    // Randomized traffic; long enough for the cycle counter to wrap.
    for (int i = 0; i < 600; i++) begin
      issue_valid   = 1'($urandom_range(0, 1));
      issue_wid     = 3'($urandom_range(0, 4));
      issue_is_csr  = ($urandom_range(0, 3) == 0);
      commit_valid  = 1'($urandom_range(0, 1));
      commit_wid    = 3'($urandom_range(0, 4));
      tmc_valid     = ($urandom_range(0, 7) == 0);
      tmc_wid       = 3'($urandom_range(0, 4));
      tmc_tmask     = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      spawn_valid   = ($urandom_range(0, 7) == 0);
      spawn_wmask   = 4'($urandom_range(0, 15));
      unlock_warp   = ($urandom_range(0, 2) == 0);
      unlock_wid    = 3'($urandom_range(0, 4));
      alm_empty_wid = 3'($urandom_range(0, 3));
      step();
    end

    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
